ecc_scrub_ctrl: RTL and testbench

Background scrubber for the Hsiao-ECC-protected cache data SRAM. It walks every set index and reads all ways through the shared SRAM port at the lowest priority. For any way whose decode reports a single-bit error, it writes the corrected data back; the write data is re-encoded by the existing encoder wrapper in front of the SRAM. Double-bit errors are counted and reported, and it raises a pass-done pulse on every index wrap.

---
 rtl/ecc_scrub_pkg.sv | 27 ++
 rtl/ecc_scrub_sat_cnt.sv | 33 +++
 rtl/ecc_scrub_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scrub_pkg.sv
// rtl/ecc_scrub_pkg.sv - shared state type and helpers for the ECC scrub controller
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        ADV
    } scrub_state_e;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Saturates at 2**width-1; callers keep width <= 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] sum;
        logic [32:0] lim;
        lim = (33'd1 << width) - 33'd1;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/ecc_scrub_sat_cnt.sv
// rtl/ecc_scrub_sat_cnt.sv - saturating accumulator that adds the popcount of a bit vector
module ecc_scrub_sat_cnt
    import ecc_scrub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [N-1:0]     vec_i,
    output logic [WIDTH-1:0] cnt_o
);

    // Popcount kept 32 bits wide so a narrow counter never wraps on a wide vector.
    logic [31:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + 32'(vec_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= WIDTH'(sat_add(32'(cnt_o), ones, WIDTH));
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background ECC scrubber for the cache data SRAM; ECC_SCRUB_CNT_EN adds error counters
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int NUM_SETS       = 256,
    parameter int ASSOC          = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16,
    localparam int IW            = idx_width(NUM_SETS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    output logic                        sram_req_o,
    input  logic                        sram_gnt_i,
    output logic                        sram_we_o,
    output logic [IW-1:0]               sram_idx_o,
    output logic [ASSOC-1:0]            sram_be_o,
    output logic [ASSOC*DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [ASSOC*DATA_WIDTH-1:0] dec_data_i,
    input  logic [ASSOC-1:0]            dec_single_err_i,
    input  logic [ASSOC-1:0]            dec_double_err_i,
    input  logic                        cache_wr_valid_i,
    input  logic [IW-1:0]               cache_wr_idx_i,
    output logic                        busy_o,
    output logic                        pass_done_o,
    output logic                        uncorr_irq_o,
    output logic [IW-1:0]               uncorr_idx_o,
    output logic [CNT_WIDTH-1:0]        corr_cnt_o,
    output logic [CNT_WIDTH-1:0]        uncorr_cnt_o
);

    localparam int TW                  = idx_width(SCRUB_INTERVAL);
    localparam logic [TW-1:0] TMR_LOAD = TW'(SCRUB_INTERVAL - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SETS - 1);

    scrub_state_e                state_q, state_d;
    logic [TW-1:0]               timer_q;
    logic [IW-1:0]               idx_q;
    logic                        conflict_q;
    logic                        stop_q;
    logic [ASSOC-1:0]            mask_q;
    logic [ASSOC*DATA_WIDTH-1:0] wdata_q;
    logic                        pass_done_q;
    logic                        irq_q;
    logic [IW-1:0]               uncorr_idx_q;
    logic [ASSOC-1:0]            wb_mask;
    logic                        wr_hit;

    assign wb_mask = dec_single_err_i & ~dec_double_err_i;
    assign wr_hit  = cache_wr_valid_i && (cache_wr_idx_i == idx_q);

    always_comb begin
        state_d    = state_q;
        sram_req_o = 1'b0;
        sram_we_o  = 1'b0;
        sram_be_o  = '0;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = WAIT;
            end
            WAIT: begin
                if (!enable_i)            state_d = IDLE;
                else if (timer_q == '0)   state_d = RD_REQ;
            end
            RD_REQ: begin
                sram_req_o = 1'b1;
                if (sram_gnt_i) state_d = RD_RSP;
            end
            RD_RSP: begin
                state_d = (wb_mask != '0) ? WR_REQ : ADV;
            end
            WR_REQ: begin
                // A cache write to this line makes the latched data stale: abort and re-read.
                if (conflict_q) begin
                    state_d = RD_REQ;
                end else begin
                    sram_req_o = 1'b1;
                    sram_we_o  = 1'b1;
                    sram_be_o  = mask_q;
                    if (sram_gnt_i) state_d = ADV;
                end
            end
            ADV: begin
                state_d = (enable_i && !stop_q) ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            conflict_q   <= 1'b0;
            stop_q       <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            pass_done_q  <= 1'b0;
            irq_q        <= 1'b0;
            uncorr_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            pass_done_q <= 1'b0;
            irq_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i) timer_q <= TMR_LOAD;
                end
                WAIT: begin
                    if (enable_i && timer_q != '0) timer_q <= timer_q - TW'(1);
                end
                RD_REQ: begin
                    if (sram_gnt_i) conflict_q <= wr_hit;
                end
                RD_RSP: begin
                    conflict_q <= conflict_q | wr_hit;
                    if (dec_double_err_i != '0) begin
                        irq_q        <= 1'b1;
                        uncorr_idx_q <= idx_q;
                    end
                    if (wb_mask != '0) begin
                        mask_q  <= wb_mask;
                        wdata_q <= dec_data_i;
                    end
                end
                WR_REQ: begin
                    conflict_q <= conflict_q | wr_hit;
                end
                ADV: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        pass_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                    timer_q <= TMR_LOAD;
                    stop_q  <= 1'b0;
                end
                default: ;
            endcase
            // Disable mid-line is remembered so the line finishes before going idle.
            if ((state_q inside {RD_REQ, RD_RSP, WR_REQ}) && !enable_i) stop_q <= 1'b1;
        end
    end

    assign sram_idx_o   = idx_q;
    assign sram_wdata_o = wdata_q;
    assign busy_o       = (state_q != IDLE) && (state_q != WAIT);
    assign pass_done_o  = pass_done_q;
    assign uncorr_irq_o = irq_q;
    assign uncorr_idx_o = uncorr_idx_q;

`ifdef ECC_SCRUB_CNT_EN
    ecc_scrub_sat_cnt #(.WIDTH(CNT_WIDTH), .N(ASSOC)) u_corr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q == RD_RSP),
        .vec_i  (wb_mask),
        .cnt_o  (corr_cnt_o)
    );

    ecc_scrub_sat_cnt #(.WIDTH(CNT_WIDTH), .N(ASSOC)) u_uncorr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q == RD_RSP),
        .vec_i  (dec_double_err_i),
        .cnt_o  (uncorr_cnt_o)
    );
`else
    assign corr_cnt_o   = '0;
    assign uncorr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb/tb_ecc_scrub_ctrl.sv - directed self-checking bench for ecc_scrub_ctrl
module tb_ecc_scrub_ctrl;

`ifdef ECC_SCRUB_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        sram_req_o;
    logic        sram_gnt_i;
    logic        sram_we_o;
    logic [1:0]  sram_idx_o;
    logic [3:0]  sram_be_o;
    logic [63:0] sram_wdata_o;
    logic [63:0] dec_data_i;
    logic [3:0]  dec_single_err_i;
    logic [3:0]  dec_double_err_i;
    logic        cache_wr_valid_i;
    logic [1:0]  cache_wr_idx_i;
    logic        busy_o;
    logic        pass_done_o;
    logic        uncorr_irq_o;
    logic [1:0]  uncorr_idx_o;
    logic [15:0] corr_cnt_o;
    logic [15:0] uncorr_cnt_o;
    logic        sc_en;
    logic [3:0]  sc_vec;
    logic [1:0]  sc_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .NUM_SETS(4), .ASSOC(4), .DATA_WIDTH(16), .SCRUB_INTERVAL(2), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
        .sram_req_o(sram_req_o), .sram_gnt_i(sram_gnt_i), .sram_we_o(sram_we_o),
        .sram_idx_o(sram_idx_o), .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o),
        .dec_data_i(dec_data_i), .dec_single_err_i(dec_single_err_i),
        .dec_double_err_i(dec_double_err_i), .cache_wr_valid_i(cache_wr_valid_i),
        .cache_wr_idx_i(cache_wr_idx_i), .busy_o(busy_o), .pass_done_o(pass_done_o),
        .uncorr_irq_o(uncorr_irq_o), .uncorr_idx_o(uncorr_idx_o),
        .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
    );

    ecc_scrub_sat_cnt #(.WIDTH(2), .N(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(sc_en), .vec_i(sc_vec), .cnt_o(sc_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; enable_i = 1'b0; sram_gnt_i = 1'b1;
        dec_data_i = '0; dec_single_err_i = '0; dec_double_err_i = '0;
        cache_wr_valid_i = 1'b0; cache_wr_idx_i = '0; sc_en = 1'b0; sc_vec = '0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic wait_read(input logic [1:0] idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sram_req_o && !sram_we_o && sram_idx_o == idx) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b0; sram_gnt_i = 1'b1;
        dec_data_i = '0; dec_single_err_i = '0; dec_double_err_i = '0;
        cache_wr_valid_i = 1'b0; cache_wr_idx_i = '0; sc_en = 1'b0; sc_vec = '0;
        tick();
        tick();
        total++;
        if ({sram_req_o, sram_we_o, sram_be_o} !== 6'b0) begin
            bad++; $display("FAIL reset_req: req=%b we=%b be=%b, want all 0", sram_req_o, sram_we_o, sram_be_o);
        end
        total++;
        if (sram_idx_o !== 2'd0 || sram_wdata_o !== 64'd0) begin
            bad++; $display("FAIL reset_idx_wdata: idx=%0d wdata=%h, want 0", sram_idx_o, sram_wdata_o);
        end
        total++;
        if ({busy_o, pass_done_o, uncorr_irq_o, uncorr_idx_o} !== 5'b0) begin
            bad++; $display("FAIL reset_status: busy=%b pd=%b irq=%b uidx=%0d, want 0", busy_o, pass_done_o, uncorr_irq_o, uncorr_idx_o);
        end
        total++;
        if (corr_cnt_o !== 16'd0 || uncorr_cnt_o !== 16'd0 || sc_cnt !== 2'd0) begin
            bad++; $display("FAIL reset_cnt: corr=%0d uncorr=%0d sat=%0d, want 0", corr_cnt_o, uncorr_cnt_o, sc_cnt);
        end
    endtask

    task automatic test_walk();
        int n, pd_n, pd_c, wr_n;
        logic [1:0] exp_idx;
        do_reset();
        enable_i = 1'b1;
        n = 0; pd_n = 0; pd_c = -1; wr_n = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 1) begin
                total++;
                if (busy_o !== 1'b0 || sram_req_o !== 1'b0) begin
                    bad++; $display("FAIL walk_wait: busy=%b req=%b, want 0 0", busy_o, sram_req_o);
                end
            end
            if (sram_req_o && sram_we_o) wr_n++;
            if (pass_done_o) begin pd_n++; pd_c = c; end
            if (sram_req_o) begin
                exp_idx = 2'(n);
                total++;
                if (c != 3 + 5 * n || sram_idx_o !== exp_idx || busy_o !== 1'b1) begin
                    bad++; $display("FAIL walk_read%0d: cycle=%0d idx=%0d busy=%b, want cycle=%0d idx=%0d busy=1",
                                    n, c, sram_idx_o, busy_o, 3 + 5 * n, exp_idx);
                end
                n++;
            end
        end
        total++;
        if (n != 5) begin bad++; $display("FAIL walk_count: reads=%0d, want 5", n); end
        total++;
        if (pd_n != 1 || pd_c != 21) begin
            bad++; $display("FAIL walk_pass_done: pulses=%0d at cycle=%0d, want 1 at 21", pd_n, pd_c);
        end
        total++;
        if (wr_n != 0) begin bad++; $display("FAIL walk_no_write: writes=%0d, want 0", wr_n); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        enable_i = 1'b1;
        wait_read(2'd2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_wait: read of idx 2 seen=%b, want 1", ok); end
        tick();
        dec_single_err_i = 4'b0010; dec_data_i = 64'h0000_0000_DEAD_0000;
        tick();
        dec_single_err_i = '0; dec_data_i = '0;
        total++;
        if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_be_o !== 4'b0010 || sram_idx_o !== 2'd2) begin
            bad++; $display("FAIL single_wr: req=%b we=%b be=%b idx=%0d, want 1 1 0010 2", sram_req_o, sram_we_o, sram_be_o, sram_idx_o);
        end
        total++;
        if (sram_wdata_o !== 64'h0000_0000_DEAD_0000) begin
            bad++; $display("FAIL single_wdata: wdata=%h, want 00000000dead0000", sram_wdata_o);
        end
        total++;
        if (corr_cnt_o !== (CNT_ON ? 16'd1 : 16'd0) || uncorr_irq_o !== 1'b0) begin
            bad++; $display("FAIL single_cnt: corr=%0d irq=%b, want %0d 0", corr_cnt_o, uncorr_irq_o, CNT_ON ? 1 : 0);
        end
        tick();
        total++;
        if (sram_req_o !== 1'b0) begin bad++; $display("FAIL single_adv: req=%b, want 0", sram_req_o); end
    endtask

    task automatic test_double();
        bit ok;
        do_reset();
        enable_i = 1'b1;
        wait_read(2'd1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL double_wait: read of idx 1 seen=%b, want 1", ok); end
        tick();
        dec_double_err_i = 4'b0001; dec_single_err_i = 4'b1000;
        dec_data_i = 64'h1234_0000_0000_5555;
        tick();
        dec_double_err_i = '0; dec_single_err_i = '0; dec_data_i = '0;
        total++;
        if (uncorr_irq_o !== 1'b1 || uncorr_idx_o !== 2'd1) begin
            bad++; $display("FAIL double_irq: irq=%b uidx=%0d, want 1 1", uncorr_irq_o, uncorr_idx_o);
        end
        total++;
        if (uncorr_cnt_o !== (CNT_ON ? 16'd1 : 16'd0) || corr_cnt_o !== (CNT_ON ? 16'd1 : 16'd0)) begin
            bad++; $display("FAIL double_cnt: uncorr=%0d corr=%0d, want %0d %0d", uncorr_cnt_o, corr_cnt_o, CNT_ON ? 1 : 0, CNT_ON ? 1 : 0);
        end
        total++;
        if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_be_o !== 4'b1000) begin
            bad++; $display("FAIL double_wr: req=%b we=%b be=%b, want 1 1 1000", sram_req_o, sram_we_o, sram_be_o);
        end
        tick();
        total++;
        if (uncorr_irq_o !== 1'b0 || uncorr_idx_o !== 2'd1) begin
            bad++; $display("FAIL double_pulse: irq=%b uidx=%0d, want 0 1", uncorr_irq_o, uncorr_idx_o);
        end
    endtask

    task automatic test_conflict();
        bit ok;
        do_reset();
        enable_i = 1'b1;
        wait_read(2'd2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL conflict_wait: read of idx 2 seen=%b, want 1", ok); end
        tick();
        dec_single_err_i = 4'b0010; dec_data_i = 64'h0000_0000_DEAD_0000; sram_gnt_i = 1'b0;
        tick();
        dec_single_err_i = '0; dec_data_i = '0;
        tick();
        total++;
        if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1) begin
            bad++; $display("FAIL conflict_stall: req=%b we=%b, want 1 1", sram_req_o, sram_we_o);
        end
        cache_wr_valid_i = 1'b1; cache_wr_idx_i = 2'd2;
        tick();
        cache_wr_valid_i = 1'b0; cache_wr_idx_i = 2'd0;
        total++;
        if (sram_req_o !== 1'b0) begin bad++; $display("FAIL conflict_drop: req=%b, want 0", sram_req_o); end
        sram_gnt_i = 1'b1;
        tick();
        total++;
        if (sram_req_o !== 1'b1 || sram_we_o !== 1'b0 || sram_idx_o !== 2'd2) begin
            bad++; $display("FAIL conflict_reread: req=%b we=%b idx=%0d, want 1 0 2", sram_req_o, sram_we_o, sram_idx_o);
        end
        tick();
        dec_single_err_i = 4'b0010; dec_data_i = 64'h0000_0000_BEEF_0000;
        tick();
        dec_single_err_i = '0; dec_data_i = '0;
        total++;
        if (sram_we_o !== 1'b1 || sram_be_o !== 4'b0010 || sram_wdata_o !== 64'h0000_0000_BEEF_0000) begin
            bad++; $display("FAIL conflict_rewrite: we=%b be=%b wdata=%h, want 1 0010 00000000beef0000", sram_we_o, sram_be_o, sram_wdata_o);
        end
        total++;
        if (corr_cnt_o !== (CNT_ON ? 16'd2 : 16'd0)) begin
            bad++; $display("FAIL conflict_cnt: corr=%0d, want %0d", corr_cnt_o, CNT_ON ? 2 : 0);
        end
    endtask

    task automatic test_stall_enable();
        bit ok;
        int bad_stall, lat;
        do_reset();
        enable_i = 1'b1; sram_gnt_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (sram_req_o) ok = 1'b1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL stall_wait: req seen=%b, want 1", ok); end
        bad_stall = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sram_req_o !== 1'b1 || sram_we_o !== 1'b0 || sram_idx_o !== 2'd0) bad_stall++;
        end
        total++;
        if (bad_stall != 0) begin bad++; $display("FAIL stall_hold: unstable cycles=%0d, want 0", bad_stall); end
        sram_gnt_i = 1'b1;
        tick();
        tick();
        tick();
        enable_i = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (busy_o !== 1'b0 || sram_req_o !== 1'b0 || sram_idx_o !== 2'd1) begin
            bad++; $display("FAIL stall_idle: busy=%b req=%b idx=%0d, want 0 0 1", busy_o, sram_req_o, sram_idx_o);
        end
        enable_i = 1'b1;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (sram_req_o && lat < 0) lat = c;
        end
        total++;
        if (lat != 3) begin bad++; $display("FAIL stall_resume: req after %0d cycles, want 3", lat); end
    endtask

    task automatic test_sat();
        do_reset();
        sc_en = 1'b1; sc_vec = 4'b0011;
        tick();
        total++;
        if (sc_cnt !== 2'd2) begin bad++; $display("FAIL sat_add2: cnt=%0d, want 2", sc_cnt); end
        sc_vec = 4'b0111;
        tick();
        total++;
        if (sc_cnt !== 2'd3) begin bad++; $display("FAIL sat_clip5: cnt=%0d, want 3", sc_cnt); end
        sc_vec = 4'b1111;
        tick();
        sc_en = 1'b0;
        total++;
        if (sc_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold: cnt=%0d, want 3", sc_cnt); end
        do_reset();
        sc_en = 1'b1; sc_vec = 4'b1111;
        tick();
        sc_en = 1'b0;
        total++;
        if (sc_cnt !== 2'd3) begin bad++; $display("FAIL sat_pop4: cnt=%0d, want 3", sc_cnt); end
    endtask

    task automatic test_reset_mid_wr();
        bit ok;
        do_reset();
        enable_i = 1'b1;
        wait_read(2'd2, ok);
        tick();
        dec_single_err_i = 4'b0100; dec_data_i = 64'h0000_7777_0000_0000; sram_gnt_i = 1'b0;
        tick();
        dec_single_err_i = '0; dec_data_i = '0;
        total++;
        if (!ok || sram_req_o !== 1'b1 || sram_we_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_setup: seen=%b req=%b we=%b, want 1 1 1", ok, sram_req_o, sram_we_o);
        end
        rst_ni = 1'b0;
        #1;
        total++;
        if ({sram_req_o, sram_we_o, sram_be_o, sram_idx_o, busy_o} !== 9'b0 || sram_wdata_o !== 64'd0) begin
            bad++; $display("FAIL rst_mid_async: req=%b we=%b be=%b idx=%0d busy=%b wdata=%h, want all 0",
                            sram_req_o, sram_we_o, sram_be_o, sram_idx_o, busy_o, sram_wdata_o);
        end
        total++;
        if (corr_cnt_o !== 16'd0 || uncorr_cnt_o !== 16'd0 || pass_done_o !== 1'b0 || uncorr_irq_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid_status: corr=%0d uncorr=%0d pd=%b irq=%b, want 0", corr_cnt_o, uncorr_cnt_o, pass_done_o, uncorr_irq_o);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_single();
        test_double();
        test_conflict();
        test_stall_enable();
        test_sat();
        test_reset_mid_wr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
